// File: rtl/dlfp16_pkg.sv
// Shared DLFloat16 execution-unit definitions: opcodes, sign-injection
// modes, opcode legality check and the command payload layout.
package dlfp16_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0001;
  localparam logic [3:0] OP_SUB    = 4'b0010;
  localparam logic [3:0] OP_MUL    = 4'b0011;
  localparam logic [3:0] OP_MINMAX = 4'b0100;
  localparam logic [3:0] OP_SGNJ   = 4'b0101;

  localparam logic [1:0] SGNJ_NEG = 2'b00;
  localparam logic [1:0] SGNJ     = 2'b01;
  localparam logic [1:0] SGNJN    = 2'b10;
  localparam logic [1:0] SGNJX    = 2'b11;

  // Command payload; the tag travels alongside it because its width is a
  // per-instance parameter.
  typedef struct packed {
    logic [3:0]  op;
    logic [1:0]  sel;
    logic [15:0] a;
    logic [15:0] b;
  } dlfp16_cmd_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SGNJ);
  endfunction

endpackage

// File: rtl/dlfp16_op_dispatch_if.sv
// Command / issue / response bundle of the DLFloat16 dispatch stage.
// master = command source and unit side, slave = dispatcher.
interface dlfp16_op_dispatch_if #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [1:0]        cmd_sel;
  logic [15:0]       cmd_a;
  logic [15:0]       cmd_b;
  logic [TAG_W-1:0]  cmd_tag;
  logic              stall;
  logic              issue_valid;
  logic [3:0]        unit_ena;
  logic [1:0]        unit_sel;
  logic [15:0]       unit_in1;
  logic [15:0]       unit_in2;
  logic              rsp_valid;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_illegal;
  logic [CW-1:0]     fifo_count;

  modport master (
    output cmd_valid, cmd_op, cmd_sel, cmd_a, cmd_b, cmd_tag, stall,
    input  cmd_ready, issue_valid, unit_ena, unit_sel, unit_in1, unit_in2,
           rsp_valid, rsp_tag, rsp_illegal, fifo_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_sel, cmd_a, cmd_b, cmd_tag, stall,
    output cmd_ready, issue_valid, unit_ena, unit_sel, unit_in1, unit_in2,
           rsp_valid, rsp_tag, rsp_illegal, fifo_count
  );
endinterface

// File: rtl/dlfp16_op_dispatch_cmd_fifo.sv
// Command FIFO for the dispatch stage: DEPTH x W storage with occupancy,
// full and empty flags. Pushes while full and pops while empty are ignored.
module dlfp16_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Occupancy update from the qualified push/pop pair
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array, written at the write pointer
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/dlfp16_op_dispatch.sv
// Issue stage in front of the DLFloat16 execution units: buffers commands,
// issues one per clock onto the unit bus and carries each tag through a
// latency-matched pipe so it lines up with the unit's registered result.
// Optional feature: define DLFP16_DISPATCH_BYPASS_EN to let a command
// arriving at an empty, unstalled FIFO load the issue register directly.
module dlfp16_op_dispatch
  import dlfp16_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int LATENCY = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  dlfp16_op_dispatch_if.slave bus
);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int CMD_W = $bits(dlfp16_cmd_t);
  localparam int FW    = CMD_W + TAG_W;

  dlfp16_cmd_t      in_cmd, head_cmd, src_cmd;
  logic [TAG_W-1:0] head_tag, src_tag;
  logic [FW-1:0]    fifo_rdata;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full, fifo_empty;
  logic             push, pop, bypass, fire, src_legal;
  logic             rdy_q;

  assign in_cmd               = {bus.cmd_op, bus.cmd_sel, bus.cmd_a, bus.cmd_b};
  assign {head_cmd, head_tag} = fifo_rdata;

  // cmd_ready is held low while in reset so every output reads 0 there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

  assign bus.cmd_ready = rdy_q && !fifo_full;

`ifdef DLFP16_DISPATCH_BYPASS_EN
  assign bypass = fifo_empty && !bus.stall && bus.cmd_valid && rdy_q;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed command is consumed by the issue register, not stored
  assign push      = bus.cmd_valid && bus.cmd_ready && !bypass;
  assign pop       = !bus.stall && !fifo_empty;
  assign fire      = pop || bypass;
  assign src_cmd   = bypass ? in_cmd : head_cmd;
  assign src_tag   = bypass ? bus.cmd_tag : head_tag;
  assign src_legal = is_legal_op(src_cmd.op);

  dlfp16_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({in_cmd, bus.cmd_tag}),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.fifo_count = fifo_count;

  logic             issue_valid_q;
  logic [3:0]       unit_ena_q;
  logic [1:0]       unit_sel_q;
  logic [15:0]      unit_in1_q, unit_in2_q;
  logic             iss_v_q, iss_ill_q;
  logic [TAG_W-1:0] iss_tag_q;

  // Issue register: loaded every clock, unit bus zeroed when idle or illegal
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid_q <= 1'b0;
      unit_ena_q    <= '0;
      unit_sel_q    <= '0;
      unit_in1_q    <= '0;
      unit_in2_q    <= '0;
      iss_v_q       <= 1'b0;
      iss_tag_q     <= '0;
      iss_ill_q     <= 1'b0;
    end else begin
      issue_valid_q <= fire && src_legal;
      unit_ena_q    <= (fire && src_legal) ? src_cmd.op  : '0;
      unit_sel_q    <= (fire && src_legal) ? src_cmd.sel : '0;
      unit_in1_q    <= (fire && src_legal) ? src_cmd.a   : '0;
      unit_in2_q    <= (fire && src_legal) ? src_cmd.b   : '0;
      iss_v_q       <= fire;
      iss_tag_q     <= fire ? src_tag : '0;
      iss_ill_q     <= fire && !src_legal;
    end
  end

  assign bus.issue_valid = issue_valid_q;
  assign bus.unit_ena    = unit_ena_q;
  assign bus.unit_sel    = unit_sel_q;
  assign bus.unit_in1    = unit_in1_q;
  assign bus.unit_in2    = unit_in2_q;

  logic             pv_q   [LATENCY];
  logic [TAG_W-1:0] ptag_q [LATENCY];
  logic             pill_q [LATENCY];

  // Tracking pipe fed from the issue register, so the last stage updates on
  // the same edge as the unit's registered result; never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < unsigned'(LATENCY); i++) begin
        pv_q[i]   <= 1'b0;
        ptag_q[i] <= '0;
        pill_q[i] <= 1'b0;
      end
    end else begin
      pv_q[0]   <= iss_v_q;
      ptag_q[0] <= iss_tag_q;
      pill_q[0] <= iss_ill_q;
      for (int unsigned i = 1; i < unsigned'(LATENCY); i++) begin
        pv_q[i]   <= pv_q[i-1];
        ptag_q[i] <= ptag_q[i-1];
        pill_q[i] <= pill_q[i-1];
      end
    end
  end

  assign bus.rsp_valid   = pv_q[LATENCY-1];
  assign bus.rsp_tag     = ptag_q[LATENCY-1];
  assign bus.rsp_illegal = pill_q[LATENCY-1];
endmodule
